// File: rtl/simulador_teleferico_pkg.sv
// Shared constants and state encoding for the cable-car plant model.
package teleferico_pkg;

  localparam logic [4:0] CURSO      = 5'd16;
  localparam logic [4:0] PERTO      = 5'd3;
  localparam logic [4:0] VEL_LENTA  = 5'd1;
  localparam logic [4:0] VEL_NORMAL = 5'd2;

  typedef enum logic [1:0] {
    PARADO    = 2'd0,
    SUBINDO_A = 2'd1,
    SUBINDO_B = 2'd2,
    FALHA     = 2'd3
  } estado_t;

endpackage

// File: rtl/simulador_teleferico_if.sv
// Command and sensor bundle between the controller under test (master)
// and the cable-car plant model (slave).
interface teleferico_if;

  logic       passo;
  logic       subir_A;
  logic       subir_B;
  logic       lento;
  logic       perto_base;
  logic       perto_topo;
  logic       chegou_base;
  logic       chegou_topo;
  logic [4:0] pos_A;
  logic       falha;

  modport master (
    output passo, subir_A, subir_B, lento,
    input  perto_base, perto_topo, chegou_base, chegou_topo, pos_A, falha
  );

  modport slave (
    input  passo, subir_A, subir_B, lento,
    output perto_base, perto_topo, chegou_base, chegou_topo, pos_A, falha
  );

endinterface

// File: rtl/simulador_teleferico_sensores.sv
// Station sensor decode from the registered cabin position.
// Both cabins are symmetric (pos_B = CURSO - pos_A), so the base and top
// sensors see the same condition. With FALHA_SENSOR_EN defined an extra
// falha_sensor input can force either "arrived" sensor low for alarm tests.
module sensores_teleferico
  import teleferico_pkg::*;
(
  input  logic [4:0] pos_A,
`ifdef FALHA_SENSOR_EN
  input  logic [1:0] falha_sensor,
`endif
  output logic       perto_base,
  output logic       perto_topo,
  output logic       chegou_base,
  output logic       chegou_topo
);

  logic chegou;
  logic perto;

  assign chegou = (pos_A == 5'd0) || (pos_A == CURSO);
  assign perto  = (pos_A <= PERTO) || (pos_A >= (CURSO - PERTO));

  assign perto_base = perto;
  assign perto_topo = perto;

`ifdef FALHA_SENSOR_EN
  assign chegou_base = chegou & ~falha_sensor[0];
  assign chegou_topo = chegou & ~falha_sensor[1];
`else
  assign chegou_base = chegou;
  assign chegou_topo = chegou;
`endif

endmodule

// File: rtl/simulador_teleferico.sv
// Cable-car plant model: two counterweighted cabins on one cable, stepped
// by a 1 Hz tick. Holds cabin A position and the motion/fault FSM.
// Optional macro: FALHA_SENSOR_EN adds the falha_sensor fault-injection port.
//
//   state     | meaning
//   PARADO    | motor off, cabins hold
//   SUBINDO_A | A rising, B descending
//   SUBINDO_B | B rising, A descending
//   FALHA     | collision or conflicting command, frozen until reset
module simulador_teleferico
  import teleferico_pkg::*;
(
  input  logic       clk_2,
  input  logic       reset,
`ifdef FALHA_SENSOR_EN
  input  logic [1:0] falha_sensor,
`endif
  teleferico_if.slave bus
);

  estado_t    estado, estado_prox;
  logic [4:0] pos_reg, pos_prox;
  logic [4:0] vel;
  logic [5:0] soma;

  // State and position registers; reset parks cabin A at the top.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      estado  <= PARADO;
      pos_reg <= CURSO;
    end else begin
      estado  <= estado_prox;
      pos_reg <= pos_prox;
    end
  end

  // Next state and position; the move is applied on the same tick the
  // command is seen, so motion follows the state being entered.
  always_comb begin
    estado_prox = estado;
    pos_prox    = pos_reg;
    vel         = bus.lento ? VEL_LENTA : VEL_NORMAL;
    soma        = {1'b0, pos_reg} + {1'b0, vel};
    if (bus.passo && (estado != FALHA)) begin
      case ({bus.subir_A, bus.subir_B})
        2'b11: estado_prox = FALHA;
        2'b10: begin
          estado_prox = SUBINDO_A;
          if (soma >= {1'b0, CURSO}) begin
            pos_prox = CURSO;
            // at normal speed, reaching the end stop is an impact
            if (!bus.lento) estado_prox = FALHA;
          end else begin
            pos_prox = soma[4:0];
          end
        end
        2'b01: begin
          estado_prox = SUBINDO_B;
          if (pos_reg <= vel) begin
            pos_prox = 5'd0;
            if (!bus.lento) estado_prox = FALHA;
          end else begin
            pos_prox = pos_reg - vel;
          end
        end
        default: estado_prox = PARADO;
      endcase
    end
  end

  assign bus.pos_A = pos_reg;
  assign bus.falha = (estado == FALHA);

  sensores_teleferico u_sensores (
    .pos_A       (pos_reg),
`ifdef FALHA_SENSOR_EN
    .falha_sensor(falha_sensor),
`endif
    .perto_base  (bus.perto_base),
    .perto_topo  (bus.perto_topo),
    .chegou_base (bus.chegou_base),
    .chegou_topo (bus.chegou_topo)
  );

endmodule

// File: doc/simulador_teleferico.md
SIMULADOR_TELEFERICO -- requirements
Module: simulador_teleferico

Interface
REQ-001 The block SHALL have port clk_2, input, 1 bit: the single system clock; every register updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port passo, input, 1 bit: one-cycle step enable (1 Hz tick); the model advances only on cycles with passo=1.
REQ-004 The block SHALL have port subir_A, input, 1 bit: motor command that raises cabin A and lowers cabin B.
REQ-005 The block SHALL have port subir_B, input, 1 bit: motor command that raises cabin B and lowers cabin A.
REQ-006 The block SHALL have port lento, input, 1 bit: 1 selects slow gear, 0 selects normal gear.
REQ-007 The block SHALL have ports perto_base and perto_topo, output, 1 bit each: a cabin is within PERTO units of the base or top station.
REQ-008 The block SHALL have ports chegou_base and chegou_topo, output, 1 bit each: a cabin is exactly parked at the base or top station.
REQ-009 The block SHALL have port pos_A, output, 5 bits: position of cabin A, where 0 is the base and CURSO is the top.
REQ-010 The block SHALL have port falha, output, 1 bit: latched plant fault (collision or conflicting command).

Function
REQ-011 The block SHALL hold one position register pos_A in the range 0..CURSO; the position of cabin B SHALL always be CURSO-pos_A.
REQ-012 The state machine SHALL have the states PARADO, SUBINDO_A, SUBINDO_B and FALHA, evaluated only on cycles where passo=1.
REQ-013 Outside FALHA, on passo, the next state SHALL be: both commands asserted -> FALHA; subir_A only -> SUBINDO_A; subir_B only -> SUBINDO_B; neither -> PARADO.
REQ-014 On passo in SUBINDO_A, pos_A SHALL increase by VEL_LENTA=1 when lento=1 and by VEL_NORMAL=2 when lento=0; SUBINDO_B SHALL decrease pos_A by the same amounts.
REQ-015 In slow gear, a step that would move past 0 or CURSO SHALL saturate pos_A at that endpoint and raise no fault.
REQ-016 In normal gear, a step that reaches or would pass 0 or CURSO SHALL saturate pos_A at that endpoint and enter FALHA (impact at speed).
REQ-017 FALHA SHALL be absorbing until reset; in FALHA pos_A SHALL freeze, commands SHALL be ignored, and falha SHALL be 1.
REQ-018 The decode SHALL be chegou_base = chegou_topo = (pos_A==0 || pos_A==CURSO).
REQ-019 The decode SHALL be perto_base = perto_topo = (pos_A<=PERTO || pos_A>=CURSO-PERTO).
REQ-020 Sensor outputs SHALL be combinational from registered pos_A, so they reflect a step on the clk_2 cycle after the passo cycle.
REQ-021 When passo=0, state and pos_A SHALL hold regardless of command inputs.
REQ-022 When passo and reset are asserted together, reset SHALL win.

Reset
REQ-023 On reset, pos_A SHALL be CURSO (cabin A at top, B at base), state SHALL be PARADO, and falha SHALL be 0.
REQ-024 Consequently, after reset chegou_base=chegou_topo=perto_base=perto_topo=1; reset mid-travel or in FALHA SHALL restore these values on the next cycle.

Configuration
REQ-025 With macro FALHA_SENSOR_EN defined, the block SHALL add input falha_sensor[1:0], where bit0=1 forces chegou_base=0 and bit1=1 forces chegou_topo=0 (fault injection for alarm testing).
REQ-026 Without FALHA_SENSOR_EN, the falha_sensor port SHALL be absent and the sensors SHALL follow REQ-018 exactly.

Structure
REQ-027 Package teleferico_pkg SHALL hold CURSO=16, PERTO=3, VEL_LENTA=1, VEL_NORMAL=2 and the state enum estado_t.
REQ-028 The sensor decode (REQ-018, REQ-019, REQ-025) SHALL be a sub-module named sensores_teleferico; the FSM and position register stay in simulador_teleferico.

Verification
REQ-029 Reset then idle: pos_A=16, all four sensors=1, falha=0.
REQ-030 subir_B=1, lento=1, 3 passos: pos_A=13, perto=1, chegou=0; then lento=0, 4 passos: pos_A=5, perto=0; lento=1, 2 passos: pos_A=3, perto=1.
REQ-031 From pos_A=1, subir_B=1, lento=1, 2 passos: pos_A=0, chegou_base=1, falha=0.
REQ-032 From pos_A=2, subir_B=1, lento=0, 1 passo: pos_A=0, falha=1; a further subir_A passo leaves pos_A=0; reset gives pos_A=16, falha=0.
REQ-033 subir_A=subir_B=1 with passo: falha=1 and pos_A unchanged; commands with passo=0 for 10 cycles: pos_A unchanged.
REQ-034 With FALHA_SENSOR_EN defined, after reset, falha_sensor=2'b01: chegou_base=0, chegou_topo=1.
